// File: rtl/debug_ocimem_arbiter_pkg.sv
// Shared types and jdo field layout for the OCI monitor-RAM arbiter.
// Pure declarations, no logic, so there is no latency.
// No flow control of its own.
package debug_ocimem_arbiter_pkg;

  // Arbiter FSM states: idle/dispatch, JTAG read data phase, CPU read data phase
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_JRD  = 2'd1,
    ST_CRD  = 2'd2
  } arb_state_e;

  // Single pending JTAG operation
  typedef enum logic [1:0] {
    JOP_NONE = 2'd0,
    JOP_RD   = 2'd1,
    JOP_WR   = 2'd2
  } jop_e;

  localparam int JDO_W    = 38;
  localparam int ADDR_LSB = 17;  // address field of take_action_ocimem_a
  localparam int DATA_LSB = 3;   // 32-bit write data field of take_action_ocimem_b
  localparam int RDFLAG   = 34;  // read request flag of take_action_ocimem_a
  localparam int BE_W     = 4;

endpackage

// File: rtl/debug_ocimem_jcmd_decode.sv
// JTAG command decode: owns the address pointer, the single pending op and monitor status.
// Strobe is latched into the pending register on the edge that ends the strobe cycle.
// A strobe that arrives while an op is pending is dropped and flags monitor_error.
module debug_ocimem_jcmd_decode
  import debug_ocimem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic              jop_done,
  output logic              jpend,
  output jop_e              jop_op,
  output logic [ADDR_W-1:0] jop_addr,
  output logic [31:0]       jop_data,
  output logic              monitor_ready,
  output logic              monitor_error
);

  logic [ADDR_W-1:0] ptr_q, ptr_d;
  jop_e              op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              rdy_q, rdy_d;
  logic              err_q, err_d;

  logic              strobe;
  logic [ADDR_W-1:0] jdo_addr;
  logic [31:0]       jdo_data;
  logic              jdo_rdflag;
  logic              jdo_unused;

  assign jdo_addr   = jdo[ADDR_LSB +: ADDR_W];
  assign jdo_data   = jdo[DATA_LSB +: 32];
  assign jdo_rdflag = jdo[RDFLAG];
  assign jdo_unused = ^{jdo[JDO_W-1:RDFLAG+1], jdo[DATA_LSB-1:0]};

  assign strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  // The pending flag stays set through the whole RAM access, so it also covers "in flight".
  assign jpend  = (op_q != JOP_NONE);

  // Next-state: completion retires the op; a new strobe is either accepted or flagged as overrun.
  always_comb begin
    ptr_d  = ptr_q;
    op_d   = op_q;
    addr_d = addr_q;
    data_d = data_q;
    rdy_d  = rdy_q;
    err_d  = err_q;

    if (jop_done) begin
      op_d  = JOP_NONE;
      rdy_d = 1'b1;
    end

    if (strobe && jpend) begin
      err_d = 1'b1;
    end else if (take_action_ocimem_a) begin
      ptr_d = jdo_addr;
      err_d = 1'b0;
      // A pure address load has nothing to complete, so ready is left alone.
      if (jdo_rdflag) begin
        op_d   = JOP_RD;
        addr_d = jdo_addr;
        rdy_d  = 1'b0;
      end
    end else if (take_action_ocimem_b) begin
      op_d   = JOP_WR;
      addr_d = ptr_q;
      data_d = jdo_data;
      ptr_d  = ptr_q + 1'b1;
      rdy_d  = 1'b0;
    end else if (take_no_action_ocimem_a) begin
      op_d   = JOP_RD;
      addr_d = ptr_q;
      ptr_d  = ptr_q + 1'b1;
      rdy_d  = 1'b0;
    end
  end

  // Command state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      op_q   <= JOP_NONE;
      addr_q <= '0;
      data_q <= '0;
      rdy_q  <= 1'b1;
      err_q  <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      op_q   <= op_d;
      addr_q <= addr_d;
      data_q <= data_d;
      rdy_q  <= rdy_d;
      err_q  <= err_d;
    end
  end

  assign jop_op        = op_q;
  assign jop_addr      = addr_q;
  assign jop_data      = data_q;
  assign monitor_ready = rdy_q;
  assign monitor_error = err_q;

endmodule

// File: rtl/debug_ocimem_arbiter.sv
// Arbitrates OCI monitor RAM between JTAG commands (priority) and the CPU debug slave.
// JTAG write ready 2 cycles after strobe, read 3; CPU write 0 wait states, read 1.
// CPU is stalled by cpu_waitrequest, released only in its single acceptance cycle.
module debug_ocimem_arbiter
  import debug_ocimem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_writedata,
  input  logic [BE_W-1:0]   cpu_byteenable,
  output logic [DATA_W-1:0] cpu_readdata,
  output logic              cpu_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [BE_W-1:0]   ram_be,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  arb_state_e        state_q, state_d;
  logic [DATA_W-1:0] mondreg_q, mondreg_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;

  logic              jpend;
  jop_e              jop_op;
  logic [ADDR_W-1:0] jop_addr;
  logic [31:0]       jop_data;
  logic              jop_done;

  debug_ocimem_jcmd_decode #(
    .ADDR_W (ADDR_W)
  ) u_jcmd (
    .clk                     (clk),
    .rst_n                   (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .jop_done                (jop_done),
    .jpend                   (jpend),
    .jop_op                  (jop_op),
    .jop_addr                (jop_addr),
    .jop_data                (jop_data),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  // Dispatch and data-phase control; RAM port defaults to the CPU request.
  always_comb begin
    state_d         = state_q;
    mondreg_d       = mondreg_q;
    cpu_rdata_d     = cpu_rdata_q;
    ram_addr        = cpu_address;
    ram_wdata       = cpu_writedata;
    ram_be          = cpu_byteenable;
    ram_we          = 1'b0;
    cpu_waitrequest = 1'b1;
    jop_done        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (jpend) begin
          ram_addr  = jop_addr;
          ram_wdata = jop_data;
          ram_be    = 4'hF;
          if (jop_op == JOP_WR) begin
            ram_we   = 1'b1;
            jop_done = 1'b1;
          end else begin
            state_d = ST_JRD;
          end
        end else if (cpu_write) begin
          // An all-zero byte mask is acknowledged without touching the RAM.
          ram_we          = |cpu_byteenable;
          cpu_waitrequest = 1'b0;
        end else if (cpu_read) begin
          state_d = ST_CRD;
        end
      end
      ST_JRD: begin
        mondreg_d = ram_rdata;
        jop_done  = 1'b1;
        state_d   = ST_IDLE;
      end
      ST_CRD: begin
        cpu_rdata_d     = ram_rdata;
        cpu_waitrequest = 1'b0;
        state_d         = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Arbiter state and captured read data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      mondreg_q   <= '0;
      cpu_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mondreg_q   <= mondreg_d;
      cpu_rdata_q <= cpu_rdata_d;
    end
  end

  // Read data is forwarded straight from the RAM in the acceptance cycle, then held.
  assign cpu_readdata = (state_q == ST_CRD) ? ram_rdata : cpu_rdata_q;
  assign MonDReg      = mondreg_q;

endmodule

// File: doc/debug_ocimem_arbiter.md
Name: debug_ocimem_arbiter

Overview:
Sequences and arbitrates access to the on-chip debug monitor RAM (OCI memory). There are two requesters: JTAG host commands, arriving as sysclk-domain take_action/jdo strobes from the debug slave, and the CPU's debug-memory slave port. It owns the auto-incrementing JTAG address pointer and produces MonDReg, monitor_ready and monitor_error, which the debug slave shifts back to the host.

Parameters:
ADDR_W, 8, word-address width of monitor RAM (2^ADDR_W 32-bit words)
DATA_W, 32, data width; fixed 32, byte enables 4 bits

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
jdo  in  38  JTAG data from debug slave, valid during strobe cycle
take_action_ocimem_a  in  1  load address pointer = jdo[17+ADDR_W-1:17]; if jdo[34]=1 also queue read
take_action_ocimem_b  in  1  queue write of jdo[34:3] at pointer, then pointer++
take_no_action_ocimem_a  in  1  queue read at pointer, then pointer++
cpu_read  in  1  CPU slave read request
cpu_write  in  1  CPU slave write request
cpu_address  in  ADDR_W  CPU word address
cpu_writedata  in  32  CPU write data
cpu_byteenable  in  4  CPU byte enables
cpu_readdata  out  32  CPU read data, valid in cycle cpu_waitrequest falls on a read
cpu_waitrequest  out  1  stall CPU request
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  32  RAM write data
ram_be  out  4  RAM byte enables
ram_we  out  1  RAM write strobe
ram_rdata  in  32  RAM read data, 1-cycle synchronous latency
MonDReg  out  32  last JTAG read data
monitor_ready  out  1  JTAG command complete
monitor_error  out  1  JTAG command overrun

Behaviour:
- Reset (async, reset_n=0): pointer=0, MonDReg=0, monitor_ready=1, monitor_error=0, jpend=0, state=IDLE, ram_we=0, cpu_waitrequest=1, cpu_readdata=0.
- Strobes are mutually exclusive. A strobe at cycle N:
  - latches the op, address and data into the jpend register at edge N;
  - clears monitor_ready;
  - increments the pointer at edge N for ocimem_b and no_action_a. The op uses the pre-increment address.
- Pointer wraps from 2^ADDR_W-1 to 0.
- Overrun: a strobe while jpend=1 or while a JTAG op is in flight sets monitor_error. The strobe is dropped and the pointer is unchanged. monitor_error is cleared only by take_action_ocimem_a, which is itself accepted only if no JTAG op is pending.
- States:
  - IDLE:
    - If jpend: JTAG has priority.
      - Write: assert ram_we for one cycle, clear jpend, set monitor_ready next edge, stay IDLE.
      - Read: drive ram_addr, go to JRD.
    - Else if cpu_write: one-cycle RAM write, cpu_waitrequest=0 that cycle.
    - Else if cpu_read: drive address, go to CRD.
  - JRD: MonDReg<=ram_rdata, clear jpend, set monitor_ready, go to IDLE.
  - CRD: cpu_readdata<=ram_rdata, cpu_waitrequest=0 this cycle, go to IDLE.
- cpu_waitrequest is 1 except in the single acceptance cycle.
- A CPU request arriving in the same cycle as jpend is stalled until JTAG completes.
- A JTAG op arriving while the FSM is in CRD waits at most 1 cycle.
- Latency with no contention:
  - JTAG write: strobe at N, ram_we at N+1, monitor_ready=1 at N+2.
  - JTAG read: MonDReg valid and monitor_ready=1 at N+3.
  - CPU write: 0 wait cycles.
  - CPU read: 1 wait cycle.
- CPU writes with cpu_byteenable=0 are accepted with no RAM write.
- JTAG writes use ram_be=4'hF.

Decomposition:
- Shared package: state encoding (IDLE, JRD, CRD), JTAG op enum (NONE, RD, WR) and jdo field offsets (ADDR_LSB=17, DATA_LSB=3, RDFLAG=34).
- One natural sub-module: debug_ocimem_jcmd_decode. It decodes the strobes and jdo, manages the pointer, jpend and monitor_error, and presents the single pending op to the arbiter FSM.

Test Plan:
- Reset mid-JTAG-read (assert reset_n=0 in JRD) -> MonDReg=0, monitor_ready=1, pointer=0, no ram_we after release.
- ocimem_a with jdo address 0x10, then ocimem_b with data 0xDEADBEEF, then ocimem_a with address 0x10 and jdo[34]=1 -> ram_we at addr 0x10, MonDReg=0xDEADBEEF, monitor_ready=1 three cycles after the last strobe.
- Pointer wrap: load address 0xFF, then two no_action_a strobes -> reads at 0xFF then 0x00, final pointer 0x01.
- Contention: cpu_read to 0x20 asserted in the cycle jpend becomes 1 -> JTAG op served first, CPU waitrequest held until the JTAG op completes, then correct cpu_readdata returned.
- Overrun: ocimem_b issued on the cycle after a previous ocimem_b while a CPU read is in flight -> monitor_error=1, second write absent from RAM, pointer advanced once; a later ocimem_a clears monitor_error.
- CPU write with byteenable 4'b0101 to 0x05, then read back -> only bytes 0 and 2 updated; 0 wait cycles on the write, 1 on the read.
